// File: rtl/stage_cp_pkg.sv
// Shared definitions for the complete stage: CDB packet layout and per-FU queue entry.
// Sizing defaults for N_FU and CP_Q_DEPTH live here alongside the typedefs.
package stage_cp_pkg;

  localparam int N_FU_DEF       = 3;
  localparam int CP_Q_DEPTH_DEF = 2;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] value;
  } CP_ENTRY;

  typedef struct packed {
    logic        valid;
    logic [5:0]  tag;
    logic [31:0] value;
  } CDB_PACKET;

endpackage

// File: rtl/stage_cp_result_fifo.sv
// cp_result_fifo: single-FU result queue with push/pop/flush and an occupancy count.
// The head entry is combinationally visible so the arbiter can broadcast it directly.
module cp_result_fifo
  import stage_cp_pkg::*;
#(
  parameter int DEPTH = CP_Q_DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  CP_ENTRY                push_data,
  input  logic                   pop,
  output CP_ENTRY                head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  CP_ENTRY       mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is data-only: validity is tracked entirely by the pointers/count.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/stage_cp.sv
// Complete stage: per-FU result queues, round-robin arbiter, registered CDB broadcast.
// Optional CP_PERF_CNT_EN adds saturating broadcast and per-FU stall counters.
module stage_cp
  import stage_cp_pkg::*;
#(
  parameter int N_FU       = N_FU_DEF,
  parameter int CP_Q_DEPTH = CP_Q_DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_FU-1:0]        fu_valid,
  input  logic [N_FU-1:0][5:0]   fu_tag,
  input  logic [N_FU-1:0][31:0]  fu_value,
  output logic [N_FU-1:0]        fu_ready,
  input  logic                   rob_clear,
  output CDB_PACKET              cdb_packet
`ifdef CP_PERF_CNT_EN
  ,
  output logic [31:0]            perf_bcast_cnt,
  output logic [N_FU-1:0][15:0]  perf_stall_cnt
`endif
);

  localparam int PW = $clog2(N_FU);
  localparam int CW = $clog2(CP_Q_DEPTH) + 1;

  logic [N_FU-1:0] push;
  logic [N_FU-1:0] pop;
  logic [N_FU-1:0] request;
  CP_ENTRY         head  [N_FU];
  logic [CW-1:0]   count [N_FU];

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  CDB_PACKET       cdb_q, cdb_d;
  logic            grant_vld;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  int              idx;

  for (genvar g = 0; g < N_FU; g++) begin : g_fu
    // Ready ignores a same-cycle pop: a full queue refuses input even while draining.
    assign fu_ready[g] = (count[g] < CW'(CP_Q_DEPTH)) && !reset;
    assign push[g]     = fu_valid[g] && fu_ready[g];
    assign request[g]  = (count[g] != '0);
    assign pop[g]      = grant_vld && (grant_idx == PW'(g));

    cp_result_fifo #(
      .DEPTH (CP_Q_DEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (rob_clear),
      .push      (push[g]),
      .push_data ({fu_tag[g], fu_value[g]}),
      .pop       (pop[g]),
      .head      (head[g]),
      .count     (count[g])
    );
  end

  // Round-robin search: first requester at or after rr_ptr, wrapping upward.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < N_FU; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_FU) idx = idx - N_FU;
      cand = PW'(idx);
      if (!grant_vld && request[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_d       = cdb_q;
    cdb_d.valid = 1'b0;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == PW'(N_FU - 1)) ? '0 : grant_idx + 1'b1;
      cdb_d    = {1'b1, head[grant_idx]};
    end
  end

  // Output register stage; a squash kills the pending broadcast but keeps tag/value.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else if (rob_clear) begin
      rr_ptr_q    <= '0;
      cdb_q.valid <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  assign cdb_packet = cdb_q;

`ifdef CP_PERF_CNT_EN
  logic [31:0]           bcast_cnt_q;
  logic [N_FU-1:0][15:0] stall_cnt_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      bcast_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (cdb_q.valid) bcast_cnt_q <= sat_inc32(bcast_cnt_q);
      for (int i = 0; i < N_FU; i++) begin
        if (fu_valid[i] && !fu_ready[i]) stall_cnt_q[i] <= sat_inc16(stall_cnt_q[i]);
      end
    end
  end

  assign perf_bcast_cnt = bcast_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stage_cp.sv
// Scoreboard bench for stage_cp: a cycle model predicts ready and each broadcast,
// expected packets are queued at stimulus time and popped when the CDB is sampled.
module tb_stage_cp;
  import stage_cp_pkg::*;

  logic              clock;
  logic              reset;
  logic [2:0]        fu_valid;
  logic [2:0][5:0]   fu_tag;
  logic [2:0][31:0]  fu_value;
  logic [2:0]        fu_ready;
  logic              rob_clear;
  CDB_PACKET         cdb_packet;
`ifdef CP_PERF_CNT_EN
  logic [31:0]       perf_bcast_cnt;
  logic [2:0][15:0]  perf_stall_cnt;
`endif

  stage_cp #(.N_FU(3), .CP_Q_DEPTH(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .fu_valid   (fu_valid),
    .fu_tag     (fu_tag),
    .fu_value   (fu_value),
    .fu_ready   (fu_ready),
    .rob_clear  (rob_clear),
    .cdb_packet (cdb_packet)
`ifdef CP_PERF_CNT_EN
    ,
    .perf_bcast_cnt (perf_bcast_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [37:0] src [3][$];
  logic [37:0] mq  [3][$];
  logic [37:0] sb  [$];
  int          mrr;
  logic        m_vld;
  logic [5:0]  m_tag;
  logic [31:0] m_val;
  logic        full_seen;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [2:0]  mready;
    logic [2:0]  acc;
    logic [37:0] e;
    int          g;
    int          c;
    for (int i = 0; i < 3; i++) begin
      fu_valid[i] = (src[i].size() > 0);
      if (fu_valid[i]) begin
        fu_tag[i]   = src[i][0][37:32];
        fu_value[i] = src[i][0][31:0];
      end else begin
        fu_tag[i]   = '0;
        fu_value[i] = '0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      mready[i] = !reset && (mq[i].size() < 2);
      acc[i]    = fu_valid[i] && mready[i];
    end
    check_val("fu_ready", {61'd0, fu_ready}, {61'd0, mready});
    if (!reset && !mready[1] && fu_valid[1]) full_seen = 1'b1;
    if (reset) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      mrr = 0; m_vld = 1'b0; m_tag = '0; m_val = '0;
    end else if (rob_clear) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      mrr = 0; m_vld = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < 3; k++) begin
        c = (mrr + k) % 3;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      m_vld = 1'b0;
      if (g >= 0) begin
        e = mq[g].pop_front();
        sb.push_back(e);
        m_vld = 1'b1;
        m_tag = e[37:32];
        m_val = e[31:0];
        mrr   = (g + 1) % 3;
      end
      for (int i = 0; i < 3; i++) if (acc[i]) mq[i].push_back(src[i][0]);
    end
    for (int i = 0; i < 3; i++) if (acc[i]) e = src[i].pop_front();
    @(posedge clock);
    #1;
    check_val("cdb_valid", {63'd0, cdb_packet.valid}, {63'd0, m_vld});
    if (m_vld) begin
      e = sb.pop_front();
      check_val("cdb_tag", {58'd0, cdb_packet.tag}, {58'd0, e[37:32]});
      check_val("cdb_value", {32'd0, cdb_packet.value}, {32'd0, e[31:0]});
    end else begin
      check_val("cdb_tag_hold", {58'd0, cdb_packet.tag}, {58'd0, m_tag});
      check_val("cdb_value_hold", {32'd0, cdb_packet.value}, {32'd0, m_val});
    end
  endtask

  function automatic logic [37:0] ent(input logic [5:0] t, input logic [31:0] v);
    return {t, v};
  endfunction

  function automatic int pending();
    int n;
    n = sb.size();
    for (int i = 0; i < 3; i++) n += src[i].size() + mq[i].size();
    return n;
  endfunction

  initial begin
    reset = 1'b1; rob_clear = 1'b0; full_seen = 1'b0; mrr = 0;
    m_vld = 1'b0; m_tag = '0; m_val = '0;
    fu_valid = '0; fu_tag = '0; fu_value = '0;

    // Reset then idle
    step(); step();
    check_val("rst_valid", {63'd0, cdb_packet.valid}, 64'd0);
    check_val("rst_tag", {58'd0, cdb_packet.tag}, 64'd0);
    check_val("rst_value", {32'd0, cdb_packet.value}, 64'd0);
    reset = 1'b0;
    #1;
    check_val("ready_after_rst", {61'd0, fu_ready}, 64'd7);
    step(); step();

    // Single FU0 result: invalid after push edge, valid after the next, then idle
    src[0].push_back(ent(6'h01, 32'h123));
    step();
    check_val("lat_push_edge", {63'd0, cdb_packet.valid}, 64'd0);
    step();
    check_val("lat_bcast_tag", {58'd0, cdb_packet.tag}, 64'h01);
    check_val("lat_bcast_val", {32'd0, cdb_packet.value}, 64'h123);
    step();
    check_val("lat_after", {63'd0, cdb_packet.valid}, 64'd0);

    // Squash an idle stage to bring rr_ptr back to 0
    rob_clear = 1'b1; step(); rob_clear = 1'b0;

    // Simultaneous pushes on all three FUs
    src[0].push_back(ent(6'h02, 32'h2000));
    src[1].push_back(ent(6'h03, 32'h3000));
    src[2].push_back(ent(6'h04, 32'h4000));
    step();
    step(); check_val("rr_first", {58'd0, cdb_packet.tag}, 64'h02);
    step(); check_val("rr_second", {58'd0, cdb_packet.tag}, 64'h03);
    step(); check_val("rr_third", {58'd0, cdb_packet.tag}, 64'h04);
    step();

    // FU1 back-to-back under contention from FU0 and FU2
    for (int i = 0; i < 3; i++) src[1].push_back(ent(6'h05 + 6'(i), 32'h5000 + 32'(i)));
    for (int i = 0; i < 6; i++) begin
      src[0].push_back(ent(6'h10 + 6'(i), 32'hA000 + 32'(i)));
      src[2].push_back(ent(6'h20 + 6'(i), 32'hC000 + 32'(i)));
    end
    for (int n = 0; n < 40 && pending() > 0; n++) step();
    check_val("fu1_full_seen", {63'd0, full_seen}, 64'd1);
    check_val("contention_drained", 64'(pending()), 64'd0);
    step();

    // Squash with results queued/in flight, then a normal push
    src[0].push_back(ent(6'h08, 32'h8));
    src[0].push_back(ent(6'h09, 32'h9));
    step();
    rob_clear = 1'b1; step(); rob_clear = 1'b0;
    check_val("clr_valid", {63'd0, cdb_packet.valid}, 64'd0);
    step(); step();
    src[0].push_back(ent(6'h0A, 32'hA));
    step(); step();
    check_val("post_clr_tag", {58'd0, cdb_packet.tag}, 64'h0A);
    step();

    // Reset mid-stream with results queued
    src[0].push_back(ent(6'h30, 32'h30)); src[0].push_back(ent(6'h31, 32'h31));
    src[1].push_back(ent(6'h32, 32'h32)); src[1].push_back(ent(6'h33, 32'h33));
    src[2].push_back(ent(6'h34, 32'h34)); src[2].push_back(ent(6'h35, 32'h35));
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) src[i].delete();
    step();
    check_val("midrst_valid", {63'd0, cdb_packet.valid}, 64'd0);
    check_val("midrst_tag", {58'd0, cdb_packet.tag}, 64'd0);
    reset = 1'b0;
    for (int n = 0; n < 5; n++) step();

    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
